// File: rtl/burst_mem_arbiter.sv
// Round-robin arbiter moving whole cache lines between the I/D caches and one burst memory port.
// Optional grant/contention counters are built when BURST_ARB_PERF_EN is defined.
module burst_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int BEAT_W = 64,
    parameter int BEATS  = 4,
    localparam int LINE_W = BEATS * BEAT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] dfp_addr,
    input  logic              dfp_read,
    output logic [LINE_W-1:0] dfp_rdata,
    output logic              dfp_resp,
    input  logic [ADDR_W-1:0] dfp_daddr,
    input  logic              dfp_dread,
    input  logic              dfp_dwrite,
    input  logic [LINE_W-1:0] dfp_dwdata,
    output logic [LINE_W-1:0] dfp_drdata,
    output logic              dfp_dresp,
    output logic [ADDR_W-1:0] bmem_addr,
    output logic              bmem_read,
    output logic              bmem_write,
    output logic [BEAT_W-1:0] bmem_wdata,
    input  logic              bmem_ready,
    input  logic [ADDR_W-1:0] bmem_raddr,
    input  logic [BEAT_W-1:0] bmem_rdata,
    input  logic              bmem_rvalid,
    output logic [31:0]       perf_icache_grants,
    output logic [31:0]       perf_dcache_grants,
    output logic [31:0]       perf_contention
);
    localparam int OFF_W = $clog2(LINE_W / 8);
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [ADDR_W-1:0] ADDR_MASK = {{(ADDR_W-OFF_W){1'b1}}, {OFF_W{1'b0}}};
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RD_CMD    = 3'd1,
        RD_GATHER = 3'd2,
        WR_BURST  = 3'd3,
        RESP      = 3'd4
    } state_t;

    state_t             state_r;
    logic               last_grant_d_r;
    logic               gnt_d_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [LINE_W-1:0]  line_r;

    logic               req_i_s;
    logic               req_d_s;
    logic               both_req_s;
    logic               grant_valid_s;
    logic               grant_d_s;
    logic               grant_wr_s;
    logic [ADDR_W-1:0]  grant_addr_s;
    logic               beat_hit_s;
    logic               last_beat_s;
    logic [CNT_W-1:0]   next_cnt_s;
    logic [LINE_W-1:0]  line_merge_s;

    // Arbitration: single requester wins outright, simultaneous requests alternate.
    always_comb begin
        req_i_s       = dfp_read;
        req_d_s       = dfp_dread | dfp_dwrite;
        both_req_s    = req_i_s & req_d_s;
        grant_valid_s = req_i_s | req_d_s;
        grant_d_s     = 1'b0;
        grant_wr_s    = 1'b0;
        grant_addr_s  = {ADDR_W{1'b0}};
        if (both_req_s) begin
            grant_d_s = ~last_grant_d_r;
        end else if (req_d_s) begin
            grant_d_s = 1'b1;
        end else begin
            grant_d_s = 1'b0;
        end
        if (grant_d_s) begin
            grant_addr_s = dfp_daddr & ADDR_MASK;
            grant_wr_s   = dfp_dwrite;
        end else begin
            grant_addr_s = dfp_addr & ADDR_MASK;
            grant_wr_s   = 1'b0;
        end
    end

    // Beat bookkeeping and the line as it will look once the current read beat lands.
    always_comb begin
        beat_hit_s   = bmem_rvalid && (bmem_raddr == bmem_addr);
        last_beat_s  = (cnt_r == LAST_BEAT);
        next_cnt_s   = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        line_merge_s = line_r;
        line_merge_s[int'(cnt_r) * BEAT_W +: BEAT_W] = bmem_rdata;
    end

    // Transaction FSM; all memory and cache-side outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= IDLE;
            last_grant_d_r <= 1'b1;
            gnt_d_r        <= 1'b0;
            cnt_r          <= {CNT_W{1'b0}};
            line_r         <= {LINE_W{1'b0}};
            dfp_rdata      <= {LINE_W{1'b0}};
            dfp_drdata     <= {LINE_W{1'b0}};
            dfp_resp       <= 1'b0;
            dfp_dresp      <= 1'b0;
            bmem_addr      <= {ADDR_W{1'b0}};
            bmem_read      <= 1'b0;
            bmem_write     <= 1'b0;
            bmem_wdata     <= {BEAT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    dfp_resp  <= 1'b0;
                    dfp_dresp <= 1'b0;
                    if (grant_valid_s) begin
                        gnt_d_r        <= grant_d_s;
                        last_grant_d_r <= grant_d_s;
                        bmem_addr      <= grant_addr_s;
                        cnt_r          <= {CNT_W{1'b0}};
                        if (grant_wr_s) begin
                            line_r     <= dfp_dwdata;
                            bmem_write <= 1'b1;
                            bmem_wdata <= dfp_dwdata[BEAT_W-1:0];
                            state_r    <= WR_BURST;
                        end else begin
                            bmem_read  <= 1'b1;
                            state_r    <= RD_CMD;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RD_CMD: begin
                    if (bmem_ready) begin
                        bmem_read <= 1'b0;
                        state_r   <= RD_GATHER;
                    end else begin
                        state_r   <= RD_CMD;
                    end
                end
                RD_GATHER: begin
                    // Beats tagged with another address belong to someone else and are dropped.
                    if (beat_hit_s) begin
                        line_r <= line_merge_s;
                        if (last_beat_s) begin
                            cnt_r   <= {CNT_W{1'b0}};
                            state_r <= RESP;
                            if (gnt_d_r) begin
                                dfp_drdata <= line_merge_s;
                                dfp_dresp  <= 1'b1;
                            end else begin
                                dfp_rdata  <= line_merge_s;
                                dfp_resp   <= 1'b1;
                            end
                        end else begin
                            cnt_r <= next_cnt_s;
                        end
                    end else begin
                        state_r <= RD_GATHER;
                    end
                end
                WR_BURST: begin
                    if (bmem_ready) begin
                        if (last_beat_s) begin
                            bmem_write <= 1'b0;
                            cnt_r      <= {CNT_W{1'b0}};
                            dfp_dresp  <= 1'b1;
                            state_r    <= RESP;
                        end else begin
                            cnt_r      <= next_cnt_s;
                            bmem_wdata <= line_r[int'(next_cnt_s) * BEAT_W +: BEAT_W];
                        end
                    end else begin
                        state_r <= WR_BURST;
                    end
                end
                RESP: begin
                    dfp_resp  <= 1'b0;
                    dfp_dresp <= 1'b0;
                    state_r   <= IDLE;
                end
                default: begin
                    dfp_resp   <= 1'b0;
                    dfp_dresp  <= 1'b0;
                    bmem_read  <= 1'b0;
                    bmem_write <= 1'b0;
                    cnt_r      <= {CNT_W{1'b0}};
                    state_r    <= IDLE;
                end
            endcase
        end
    end

`ifdef BURST_ARB_PERF_EN
    logic [31:0] perf_i_r;
    logic [31:0] perf_d_r;
    logic [31:0] perf_c_r;
    logic        in_idle_s;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        if (en && (v != 32'hFFFF_FFFF)) begin
            sat_inc = v + 32'd1;
        end else begin
            sat_inc = v;
        end
    endfunction

    // Decode when an IDLE cycle hands out a grant.
    always_comb begin
        in_idle_s = (state_r == IDLE);
    end

    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_i_r <= 32'd0;
            perf_d_r <= 32'd0;
            perf_c_r <= 32'd0;
        end else begin
            perf_i_r <= sat_inc(perf_i_r, in_idle_s & grant_valid_s & ~grant_d_s);
            perf_d_r <= sat_inc(perf_d_r, in_idle_s & grant_valid_s & grant_d_s);
            perf_c_r <= sat_inc(perf_c_r, in_idle_s & both_req_s);
        end
    end

    assign perf_icache_grants = perf_i_r;
    assign perf_dcache_grants = perf_d_r;
    assign perf_contention    = perf_c_r;
`else
    assign perf_icache_grants = 32'd0;
    assign perf_dcache_grants = 32'd0;
    assign perf_contention    = 32'd0;
`endif

endmodule

// File: tb/tb_burst_mem_arbiter.sv
// Scoreboard bench for burst_mem_arbiter: stimulus queues expected commands, beats and
// responses; a negedge monitor pops and compares whenever the DUT presents them.
module tb_burst_mem_arbiter;
    localparam int ADDR_W = 32;
    localparam int BEAT_W = 64;
    localparam int BEATS  = 4;
    localparam int LINE_W = 256;

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] dfp_addr;
    logic              dfp_read;
    logic [LINE_W-1:0] dfp_rdata;
    logic              dfp_resp;
    logic [ADDR_W-1:0] dfp_daddr;
    logic              dfp_dread;
    logic              dfp_dwrite;
    logic [LINE_W-1:0] dfp_dwdata;
    logic [LINE_W-1:0] dfp_drdata;
    logic              dfp_dresp;
    logic [ADDR_W-1:0] bmem_addr;
    logic              bmem_read;
    logic              bmem_write;
    logic [BEAT_W-1:0] bmem_wdata;
    logic              bmem_ready;
    logic [ADDR_W-1:0] bmem_raddr;
    logic [BEAT_W-1:0] bmem_rdata;
    logic              bmem_rvalid;
    logic [31:0]       perf_icache_grants;
    logic [31:0]       perf_dcache_grants;
    logic [31:0]       perf_contention;

    int checks = 0;
    int errors = 0;
    logic [31:0]  cmd_q[$];
    logic [63:0]  wd_q[$];
    logic [255:0] iq[$];
    logic [255:0] dq[$];
    logic [255:0] d_hold = 256'd0;
    logic         prev_resp = 1'b0;
    logic         prev_dresp = 1'b0;

    burst_mem_arbiter #(.ADDR_W(ADDR_W), .BEAT_W(BEAT_W), .BEATS(BEATS)) dut (
        .clk(clk), .rst(rst),
        .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp),
        .dfp_daddr(dfp_daddr), .dfp_dread(dfp_dread), .dfp_dwrite(dfp_dwrite),
        .dfp_dwdata(dfp_dwdata), .dfp_drdata(dfp_drdata), .dfp_dresp(dfp_dresp),
        .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
        .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
        .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid),
        .perf_icache_grants(perf_icache_grants), .perf_dcache_grants(perf_dcache_grants),
        .perf_contention(perf_contention)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] align(input logic [31:0] a);
        return a & 32'hFFFF_FFE0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a command, beat or response.
    always @(negedge clk) begin
        if (rst) begin
            prev_resp  = 1'b0;
            prev_dresp = 1'b0;
        end else begin
            if (bmem_read && bmem_ready) begin
                chk("cmd_expected", 256'(cmd_q.size() > 0), 256'(1));
                if (cmd_q.size() > 0) chk("cmd_addr", 256'(bmem_addr), 256'(cmd_q.pop_front()));
            end
            if (bmem_write) begin
                chk("wbeat_expected", 256'(wd_q.size() > 0), 256'(1));
                if (wd_q.size() > 0) chk("wbeat_data", 256'(bmem_wdata), 256'(wd_q.pop_front()));
            end
            if (dfp_resp) begin
                chk("iresp_expected", 256'(iq.size() > 0), 256'(1));
                chk("iresp_one_cycle", 256'(prev_resp), 256'(0));
                if (iq.size() > 0) chk("iresp_rdata", dfp_rdata, iq.pop_front());
            end
            if (dfp_dresp) begin
                chk("dresp_expected", 256'(dq.size() > 0), 256'(1));
                chk("dresp_one_cycle", 256'(prev_dresp), 256'(0));
                if (dq.size() > 0) chk("dresp_drdata", dfp_drdata, dq.pop_front());
            end
            prev_resp  = dfp_resp;
            prev_dresp = dfp_dresp;
        end
    end

    task automatic expect_read(input bit dside, input logic [31:0] addr, input logic [255:0] line);
        cmd_q.push_back(align(addr));
        if (dside) begin
            dq.push_back(line);
            d_hold = line;
        end else begin
            iq.push_back(line);
        end
    endtask

    // Memory side: wait for the read command, accept it, then one idle latency cycle.
    task automatic mem_cmd();
        int n = 0;
        bmem_ready = 1'b1;
        while (!bmem_read && n < 50) begin
            tick();
            n++;
        end
        chk("cmd_wait_bound", 256'(n < 50), 256'(1));
        tick();
        tick();
    endtask

    task automatic mem_beats(input logic [31:0] addr, input logic [255:0] line,
                             input int first, input int last, input int bad_at);
        for (int k = first; k < last; k++) begin
            if (k == bad_at) begin
                bmem_rvalid = 1'b1;
                bmem_raddr  = 32'hDEAD_0000;
                bmem_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
                tick();
            end
            bmem_rvalid = 1'b1;
            bmem_raddr  = align(addr);
            bmem_rdata  = line[64*k +: 64];
            tick();
        end
        bmem_rvalid = 1'b0;
        bmem_raddr  = 32'd0;
        bmem_rdata  = 64'd0;
    endtask

    task automatic wait_resp(input bit dside);
        int n = 0;
        while (!(dside ? dfp_dresp : dfp_resp) && n < 50) begin
            tick();
            n++;
        end
        chk("resp_wait_bound", 256'(n < 50), 256'(1));
    endtask

    task automatic do_iread(input logic [31:0] addr, input logic [255:0] line, input int bad_at);
        expect_read(1'b0, addr, line);
        dfp_addr = addr;
        dfp_read = 1'b1;
        mem_cmd();
        mem_beats(addr, line, 0, 4, bad_at);
        wait_resp(1'b0);
        dfp_read = 1'b0;
        tick();
        chk("iresp_dropped", 256'(dfp_resp), 256'(0));
    endtask

    task automatic do_dread(input logic [31:0] addr, input logic [255:0] line, input int bad_at);
        expect_read(1'b1, addr, line);
        dfp_daddr = addr;
        dfp_dread = 1'b1;
        mem_cmd();
        mem_beats(addr, line, 0, 4, bad_at);
        wait_resp(1'b1);
        dfp_dread = 1'b0;
        tick();
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [255:0] line,
                            input int stall_at, input int stall_len, input int exp_ticks);
        int acc = 0;
        int stall = stall_len;
        int ticks = 0;
        bit addr_seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wd_q.push_back(line[64*k +: 64]);
            if (k == stall_at) for (int s = 0; s < stall_len; s++) wd_q.push_back(line[64*k +: 64]);
        end
        dq.push_back(d_hold);
        dfp_daddr  = addr;
        dfp_dwdata = line;
        dfp_dwrite = 1'b1;
        bmem_ready = 1'b1;
        while (!dfp_dresp && ticks < 100) begin
            if (bmem_write && !addr_seen) begin
                chk("wr_addr", 256'(bmem_addr), 256'(align(addr)));
                addr_seen = 1'b1;
            end
            if (bmem_write && acc == stall_at && stall > 0) begin
                bmem_ready = 1'b0;
                stall--;
            end else begin
                bmem_ready = 1'b1;
            end
            if (bmem_write && bmem_ready) acc++;
            tick();
            ticks++;
        end
        chk("wr_resp_seen", 256'(dfp_dresp), 256'(1));
        chk("wr_latency", 256'(ticks), 256'(exp_ticks));
        chk("wr_beats_accepted", 256'(acc), 256'(4));
        dfp_dwrite = 1'b0;
        bmem_ready = 1'b1;
        tick();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_bmem_read"},  256'(bmem_read),  256'(0));
        chk({tag, "_bmem_write"}, 256'(bmem_write), 256'(0));
        chk({tag, "_bmem_addr"},  256'(bmem_addr),  256'(0));
        chk({tag, "_bmem_wdata"}, 256'(bmem_wdata), 256'(0));
        chk({tag, "_resp"},       256'(dfp_resp),   256'(0));
        chk({tag, "_dresp"},      256'(dfp_dresp),  256'(0));
        chk({tag, "_rdata"},      dfp_rdata,        256'(0));
        chk({tag, "_drdata"},     dfp_drdata,       256'(0));
        chk({tag, "_perf_i"},     256'(perf_icache_grants), 256'(0));
        chk({tag, "_perf_d"},     256'(perf_dcache_grants), 256'(0));
        chk({tag, "_perf_c"},     256'(perf_contention),    256'(0));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        logic [255:0] l1, l3i, l3d, l4, l5, l6a, l6b, lw, lw2;
        l1  = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
               64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        l3i = {64'h0000_0000_0000_00A3, 64'h0000_0000_0000_00A2,
               64'h0000_0000_0000_00A1, 64'h0000_0000_0000_00A0};
        l3d = {64'h0000_0000_0000_00B3, 64'h0000_0000_0000_00B2,
               64'h0000_0000_0000_00B1, 64'h0000_0000_0000_00B0};
        l4  = {64'hC3C3_0000_0000_0003, 64'hC2C2_0000_0000_0002,
               64'hC1C1_0000_0000_0001, 64'hC0C0_0000_0000_0000};
        l5  = {64'h5555_0000_0000_5553, 64'h5555_0000_0000_5552,
               64'h5555_0000_0000_5551, 64'h5555_0000_0000_5550};
        l6a = {64'h6A6A_0000_0000_0003, 64'h6A6A_0000_0000_0002,
               64'h6A6A_0000_0000_0001, 64'h6A6A_0000_0000_0000};
        l6b = {64'h6B6B_0000_0000_0003, 64'h6B6B_0000_0000_0002,
               64'h6B6B_0000_0000_0001, 64'h6B6B_0000_0000_0000};
        lw  = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
               64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
        lw2 = {64'h7777_0000_0000_0004, 64'h7777_0000_0000_0003,
               64'h7777_0000_0000_0002, 64'h7777_0000_0000_0001};

        rst = 1'b1;
        dfp_addr = 32'd0; dfp_read = 1'b0; dfp_daddr = 32'd0; dfp_dread = 1'b0;
        dfp_dwrite = 1'b0; dfp_dwdata = 256'd0; bmem_ready = 1'b1;
        bmem_raddr = 32'd0; bmem_rdata = 64'd0; bmem_rvalid = 1'b0;
        repeat (3) tick();
        check_zero("reset");

        // Both caches requesting as reset lifts: I first (last_grant=D), then D.
        expect_read(1'b0, 32'h0000_1100, l3i);
        expect_read(1'b1, 32'h0000_2200, l3d);
        dfp_addr = 32'h0000_1100; dfp_read = 1'b1;
        dfp_daddr = 32'h0000_2200; dfp_dread = 1'b1;
        rst = 1'b0;
        mem_cmd();
        mem_beats(32'h0000_1100, l3i, 0, 4, -1);
        wait_resp(1'b0);
        dfp_read = 1'b0;
        mem_cmd();
        mem_beats(32'h0000_2200, l3d, 0, 4, -1);
        wait_resp(1'b1);
        dfp_dread = 1'b0;
        tick();
`ifdef BURST_ARB_PERF_EN
        chk("perf_contention", 256'(perf_contention), 256'(1));
        chk("perf_i_grants", 256'(perf_icache_grants), 256'(1));
        chk("perf_d_grants", 256'(perf_dcache_grants), 256'(1));
`else
        chk("perf_contention", 256'(perf_contention), 256'(0));
        chk("perf_i_grants", 256'(perf_icache_grants), 256'(0));
        chk("perf_d_grants", 256'(perf_dcache_grants), 256'(0));
`endif

        // I-cache read of an unaligned address.
        do_iread(32'h0000_1234, l1, -1);
        chk("t1_rdata_beat0", 256'(dfp_rdata[63:0]), 256'(64'h1111_1111_1111_1111));
        chk("t1_rdata_beat3", 256'(dfp_rdata[255:192]), 256'(64'h4444_4444_4444_4444));

        // Both requesting after an I grant: D wins this round.
        expect_read(1'b1, 32'h0000_6080, l3d);
        expect_read(1'b0, 32'h0000_5040, l3i);
        dfp_addr = 32'h0000_5040; dfp_read = 1'b1;
        dfp_daddr = 32'h0000_6080; dfp_dread = 1'b1;
        mem_cmd();
        mem_beats(32'h0000_6080, l3d, 0, 4, -1);
        wait_resp(1'b1);
        dfp_dread = 1'b0;
        mem_cmd();
        mem_beats(32'h0000_5040, l3i, 0, 4, -1);
        wait_resp(1'b0);
        dfp_read = 1'b0;
        tick();

        // D-cache writes: stalled second beat, then a clean burst.
        do_write(32'h8000_0040, lw, 1, 2, 7);
        do_write(32'h8000_0100, lw2, -1, 0, 5);

        // D-cache read with a foreign-tagged beat injected mid-gather.
        do_dread(32'h0000_7000, l4, 2);

        // Reset after two beats aborts the read; late beats are ignored.
        cmd_q.push_back(32'h0000_3000);
        dfp_addr = 32'h0000_3000; dfp_read = 1'b1;
        mem_cmd();
        mem_beats(32'h0000_3000, l6a, 0, 2, -1);
        rst = 1'b1;
        dfp_read = 1'b0;
        tick();
        check_zero("midrst");
        d_hold = 256'd0;
        rst = 1'b0;
        mem_beats(32'h0000_3000, l6a, 2, 4, -1);
        repeat (2) tick();
        chk("midrst_no_resp", 256'(dfp_resp), 256'(0));
        chk("midrst_idle", 256'(bmem_read), 256'(0));
        do_iread(32'h0000_3000, l5, -1);

        // Request held one cycle past the response is a second transaction.
        expect_read(1'b0, 32'h0000_4000, l6a);
        expect_read(1'b0, 32'h0000_4000, l6b);
        dfp_addr = 32'h0000_4000; dfp_read = 1'b1;
        mem_cmd();
        mem_beats(32'h0000_4000, l6a, 0, 4, -1);
        wait_resp(1'b0);
        tick();
        tick();
        dfp_read = 1'b0;
        mem_cmd();
        mem_beats(32'h0000_4000, l6b, 0, 4, -1);
        wait_resp(1'b0);
        repeat (3) tick();

        chk("cmd_q_drained", 256'(cmd_q.size()), 256'(0));
        chk("wd_q_drained", 256'(wd_q.size()), 256'(0));
        chk("iq_drained", 256'(iq.size()), 256'(0));
        chk("dq_drained", 256'(dq.size()), 256'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/burst_mem_arbiter.md
Name: burst_mem_arbiter

Overview:
- Sits between the I-cache and D-cache line ports and the single burst memory port.
- Arbitrates whole-line reads and writes between the two caches.
- Serialises each line into BEATS memory beats, and gathers read beats back into a line.
- Drives dfp_resp and dfp_dresp back to the caches; the top-level dfp_* nets are its cache-side ports.

Parameters:
ADDR_W, 32, address width
BEAT_W, 64, memory beat width in bits
BEATS, 4, beats per cache line; LINE_W = BEATS*BEAT_W (256 at defaults)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
dfp_addr  in  ADDR_W  I-cache line address
dfp_read  in  1  I-cache read request (level, held until dfp_resp)
dfp_rdata  out  LINE_W  I-cache line data
dfp_resp  out  1  I-cache response pulse
dfp_daddr  in  ADDR_W  D-cache line address
dfp_dread  in  1  D-cache read request (level)
dfp_dwrite  in  1  D-cache write request (level); never asserted together with dfp_dread
dfp_dwdata  in  LINE_W  D-cache writeback line
dfp_drdata  out  LINE_W  D-cache line data
dfp_dresp  out  1  D-cache response pulse
bmem_addr  out  ADDR_W  memory address, line-aligned
bmem_read  out  1  memory read command
bmem_write  out  1  memory write beat valid
bmem_wdata  out  BEAT_W  write beat
bmem_ready  in  1  memory accepts command/beat this cycle
bmem_raddr  in  ADDR_W  address tag of returning read beat
bmem_rdata  in  BEAT_W  read beat
bmem_rvalid  in  1  read beat valid
perf_icache_grants  out  32  I-cache grants (optional feature)
perf_dcache_grants  out  32  D-cache grants (optional feature)
perf_contention  out  32  cycles both sides requested in IDLE (optional feature)

Behaviour:
- Reset: every output is 0; state IDLE; last_grant=D; beat counter=0.
- Reset mid-transaction aborts the transaction and discards gathered beats. Beats arriving after reset are ignored.

State machine: IDLE, RD_CMD, RD_GATHER, WR_BURST, RESP.

IDLE:
- If only one side is requesting, grant it.
- If both are requesting, grant the side opposite last_grant (round-robin), then update last_grant.
- Latch the granted address with bits [log2(LINE_W/8)-1:0] forced to 0.
- Latch the direction and write data.
- Next state: RD_CMD for a read, WR_BURST for a write.

RD_CMD:
- bmem_read=1 with bmem_addr.
- Go to RD_GATHER on the first cycle bmem_ready=1; otherwise hold.

RD_GATHER:
- A beat is accepted when bmem_rvalid=1 and bmem_raddr==latched address.
- Beat k fills line[BEAT_W*k +: BEAT_W], with k counting from 0.
- Non-matching rvalid beats are dropped.
- After beat BEATS-1 is accepted, go to RESP.

WR_BURST:
- bmem_write=1, bmem_addr=latched address, bmem_wdata = beat k of the latched line.
- k advances only when bmem_ready=1; if ready is low, hold the beat.
- After beat BEATS-1 is accepted, go to RESP.

RESP:
- Exactly one cycle.
- Pulse dfp_resp or dfp_dresp for the granted side, with dfp_rdata/dfp_drdata valid that cycle. Write responses carry no data.
- Rdata outputs hold their value until the next response; they are not cleared.
- Return to IDLE.
- The requester must drop its request in the cycle after the response. A request still high in IDLE is treated as a new request.

Latency:
- Write, best case: 1 (IDLE) + BEATS + 1 = 6 cycles from request to resp with ready held high.
- Read: 2 + memory latency + BEATS + 1 cycles.

Fixed rules:
- Only one transaction is outstanding at a time.
- The non-granted side waits and is never starved; round-robin guarantees service within one transaction.
- Request inputs that change during a transaction are ignored until IDLE.

Optional Feature:
- Macro: BURST_ARB_PERF_EN.
- Defined:
  - Three 32-bit saturating counters, cleared on rst.
  - Grant counters increment on leaving IDLE.
  - perf_contention increments each IDLE cycle where both sides request.
- Undefined: the three perf ports are tied to 0 and no counter flops exist.

Test Plan:
1. I-cache read only, addr 0x0000_1234, memory returns beats 0x11.., 0x22.., 0x33.., 0x44.. → bmem_addr=0x0000_1220; dfp_rdata[63:0]=beat0 and [255:192]=beat3; dfp_resp high for exactly 1 cycle.
2. D-cache write 0x8000_0040 with line {D,C,B,A}, bmem_ready low on the 2nd beat for 2 cycles → beats A,B,B,B,C,D observed on bmem_wdata; 4 accepted beats; dfp_dresp 1 cycle later.
3. Both requesting at reset exit, then both requesting again → first grant I-cache (last_grant=D at reset), then D-cache; with PERF_EN: perf_contention=1, each grant counter=1.
4. During RD_GATHER, inject an rvalid beat with mismatched raddr 0xDEAD_0000 → beat ignored; line assembled only from matching beats.
5. Assert rst after 2 of 4 read beats → all outputs 0 next cycle; the remaining 2 beats ignored; a new I-cache read completes correctly.
6. I-cache request held high one cycle past resp → treated as a second transaction with a second resp (documents the protocol rule).
